// File: rtl/pio_pkg.sv
// Shared register map, FDEBUG/CTRL bit indices and FSTAT field positions
// for the PIO Wishbone FIFO bridge.
package pio_pkg;

  // Word offsets as decoded from wbs_adr_i[4:2]
  localparam logic [2:0] PIO_TXF    = 3'h0;
  localparam logic [2:0] PIO_RXF    = 3'h1;
  localparam logic [2:0] PIO_FSTAT  = 3'h2;
  localparam logic [2:0] PIO_FDEBUG = 3'h3;
  localparam logic [2:0] PIO_CTRL   = 3'h4;

  localparam int unsigned DBG_TXOVER  = 0;
  localparam int unsigned DBG_RXUNDER = 1;
  localparam int unsigned DBG_RXSTALL = 2;

  localparam int unsigned CTRL_TX_IRQ_EN = 0;
  localparam int unsigned CTRL_RX_IRQ_EN = 1;
  localparam int unsigned CTRL_FLUSH     = 2;

  localparam int unsigned FSTAT_TX_LVL   = 0;
  localparam int unsigned FSTAT_RX_LVL   = 4;
  localparam int unsigned FSTAT_TX_FULL  = 8;
  localparam int unsigned FSTAT_TX_EMPTY = 9;
  localparam int unsigned FSTAT_RX_FULL  = 10;
  localparam int unsigned FSTAT_RX_EMPTY = 11;

endpackage

// File: rtl/pio_sync_fifo.sv
// Single-clock FIFO with combinational head; full is judged before any
// same-cycle pop, and flush overrides push/pop.
module pio_sync_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            push_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [DATA_W-1:0]            head
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/pio_wb_fifo_bridge.sv
// Wishbone slave feeding one PIO state machine: TX FIFO (bus->SM), RX FIFO
// (SM->bus), status, sticky W1C error flags and a registered level interrupt.
module pio_wb_fifo_bridge
  import pio_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_ready_o,
  output logic              irq_o
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic          ack_q, irq_q, irq_d;
  logic [31:0]   dat_q, rdata, fstat;
  logic [1:0]    ctrl_q;
  logic [2:0]    fdebug_q, fdebug_d, dbg_set, dbg_clr;
  logic          accept, req;
  logic [2:0]    off;
  logic          wr_txf, rd_rxf, wr_fdebug, wr_ctrl, flush;
  logic          tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
  logic [LW-1:0] tx_level, rx_level;
  logic [DATA_W-1:0] rx_head;
  logic          unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  always_comb begin
    accept    = wbs_cyc_i & wbs_stb_i & ~ack_q;
    // Requests outside this window are acked with no side effect and read 0
    req       = accept & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    off       = wbs_adr_i[4:2];
    wr_txf    = req & wbs_we_i & (off == PIO_TXF) & (wbs_sel_i == 4'hF);
    rd_rxf    = req & ~wbs_we_i & (off == PIO_RXF);
    wr_fdebug = req & wbs_we_i & (off == PIO_FDEBUG);
    wr_ctrl   = req & wbs_we_i & (off == PIO_CTRL) & (wbs_sel_i == 4'hF);
    flush     = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
  end

  assign tx_valid_o = ~tx_empty;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign rx_ready_o = ~rx_full;
  assign rx_push    = rx_valid_i & rx_ready_o;

  pio_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .push      (wr_txf),
    .pop       (tx_pop),
    .flush     (flush),
    .push_data (wbs_dat_i[DATA_W-1:0]),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level),
    .head      (tx_data_o)
  );

  pio_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .push      (rx_push),
    .pop       (rd_rxf),
    .flush     (flush),
    .push_data (rx_data_i),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level),
    .head      (rx_head)
  );

  always_comb begin
    fstat                        = '0;
    fstat[FSTAT_TX_LVL +: 4]     = 4'(tx_level);
    fstat[FSTAT_RX_LVL +: 4]     = 4'(rx_level);
    fstat[FSTAT_TX_FULL]         = tx_full;
    fstat[FSTAT_TX_EMPTY]        = tx_empty;
    fstat[FSTAT_RX_FULL]         = rx_full;
    fstat[FSTAT_RX_EMPTY]        = rx_empty;

    rdata = '0;
    if (req && !wbs_we_i) begin
      unique case (off)
        PIO_RXF:    rdata = rx_empty ? '0 : 32'(rx_head);
        PIO_FSTAT:  rdata = fstat;
        PIO_FDEBUG: rdata = {29'd0, fdebug_q};
        PIO_CTRL:   rdata = {30'd0, ctrl_q};
        default:    rdata = '0;
      endcase
    end

    dbg_set              = '0;
    dbg_set[DBG_TXOVER]  = wr_txf & tx_full;
    dbg_set[DBG_RXUNDER] = rd_rxf & rx_empty;
    dbg_set[DBG_RXSTALL] = rx_valid_i & rx_full;
    dbg_clr              = wr_fdebug ? wbs_dat_i[2:0] : 3'd0;
    // Set wins over a same-cycle clear
    fdebug_d             = (fdebug_q & ~dbg_clr) | dbg_set;

    irq_d = (ctrl_q[CTRL_TX_IRQ_EN] & (tx_level < LW'(DEPTH / 2)))
          | (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ctrl_q   <= '0;
      fdebug_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= accept;
      dat_q    <= rdata;
      fdebug_q <= fdebug_d;
      irq_q    <= irq_d;
      if (wr_ctrl) ctrl_q <= wbs_dat_i[1:0];
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_pio_wb_fifo_bridge.sv
// Directed bench for pio_wb_fifo_bridge with immediate-assertion checks.
module tb_pio_wb_fifo_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [4:0] O_TXF = 5'h00, O_RXF = 5'h04, O_FSTAT = 5'h08;
  localparam logic [4:0] O_FDEBUG = 5'h0C, O_CTRL = 5'h10;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  logic [31:0] tx_data, rx_data;
  logic [31:0] rd;

  int checks   = 0;
  int failures = 0;

  pio_wb_fifo_bridge #(.DEPTH(4), .DATA_W(32), .BASE_ADDR(BASE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_ready_o (rx_ready),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transaction; optional same-cycle SM pop of the TX head
  task automatic wb_xfer(input logic w, input logic [4:0] off, input logic [31:0] d,
                         input logic [3:0] s, input logic txpop, output logic [31:0] r);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + 32'(off); wdat = d; sel = s;
    tx_ready = txpop;
    @(negedge clk);
    chk("ack", {31'd0, ack}, 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic wb_wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, off, d, 4'hF, 1'b0, dummy);
  endtask

  task automatic wb_rd(input logic [4:0] off, output logic [31:0] r);
    wb_xfer(1'b0, off, 32'd0, 4'hF, 1'b0, r);
  endtask

  task automatic sm_push(input logic [31:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_tx [4];
    exp_tx[0] = 32'h11; exp_tx[1] = 32'h22; exp_tx[2] = 32'h33; exp_tx[3] = 32'h44;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    wb_rd(O_FSTAT, rd); chk("rst_fstat", rd, 32'h0000_0A00);

    // TX overflow and drain
    wb_wr(O_TXF, 32'h11); wb_wr(O_TXF, 32'h22); wb_wr(O_TXF, 32'h33);
    wb_wr(O_TXF, 32'h44); wb_wr(O_TXF, 32'h55);
    wb_rd(O_FSTAT, rd);  chk("tx_full_fstat", rd, 32'h0000_0904);
    wb_rd(O_FDEBUG, rd); chk("txover", rd, 32'h1);
    wb_rd(O_TXF, rd);    chk("txf_read0", rd, 32'h0);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_valid_drain", {31'd0, tx_valid}, 32'd1);
      chk("tx_data_seq", tx_data, exp_tx[i]);
      @(negedge clk);
    end
    chk("tx_drained", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    wb_wr(O_FDEBUG, 32'h7);
    wb_rd(O_FDEBUG, rd); chk("fdebug_clr_all", rd, 32'h0);

    // RX path and underflow
    sm_push(32'hA000); sm_push(32'hAB00);
    wb_rd(O_FSTAT, rd); chk("rx2_fstat", rd, 32'h0000_0220);
    wb_rd(O_RXF, rd);   chk("rx_pop0", rd, 32'hA000);
    wb_rd(O_RXF, rd);   chk("rx_pop1", rd, 32'hAB00);
    wb_rd(O_RXF, rd);   chk("rx_under_data", rd, 32'h0);
    wb_rd(O_FDEBUG, rd); chk("rxunder", rd, 32'h2);
    wb_wr(O_FDEBUG, 32'h2);
    wb_rd(O_FDEBUG, rd); chk("rxunder_clr", rd, 32'h0);

    // RX interrupt
    wb_wr(O_CTRL, 32'h2);
    @(negedge clk); chk("irq_rx_empty", {31'd0, irq}, 32'd0);
    @(negedge clk); rx_valid = 1'b1; rx_data = 32'hBEEF;
    @(negedge clk); rx_valid = 1'b0;
    chk("irq_lat0", {31'd0, irq}, 32'd0);
    @(negedge clk); chk("irq_set", {31'd0, irq}, 32'd1);
    wb_rd(O_RXF, rd); chk("irq_pop_data", rd, 32'hBEEF);
    chk("irq_still", {31'd0, irq}, 32'd1);
    @(negedge clk); chk("irq_clear", {31'd0, irq}, 32'd0);

    // Same-cycle TX push and pop
    wb_wr(O_TXF, 32'h1); wb_wr(O_TXF, 32'h2);
    wb_xfer(1'b1, O_TXF, 32'h3, 4'hF, 1'b1, rd);
    wb_rd(O_FSTAT, rd); chk("pushpop_lvl2", rd, 32'h0000_0802);
    chk("pushpop_head", tx_data, 32'h2);
    wb_wr(O_TXF, 32'h4); wb_wr(O_TXF, 32'h5);
    wb_rd(O_FSTAT, rd); chk("tx_full2", rd, 32'h0000_0904);
    wb_xfer(1'b1, O_TXF, 32'h6, 4'hF, 1'b1, rd);
    wb_rd(O_FSTAT, rd); chk("full_pushpop_lvl3", rd, 32'h0000_0803);
    wb_rd(O_FDEBUG, rd); chk("full_pushpop_over", rd, 32'h1);
    chk("full_pushpop_head", tx_data, 32'h3);
    // Partial byte select: write dropped
    wb_xfer(1'b1, O_TXF, 32'h9, 4'h3, 1'b0, rd);
    wb_rd(O_FSTAT, rd); chk("sel_partial", rd, 32'h0000_0803);

    // Fill both, RX stall, flush
    wb_wr(O_TXF, 32'h7);
    for (int i = 0; i < 4; i++) sm_push(32'h100 + 32'(i));
    chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
    sm_push(32'hDEAD);
    wb_rd(O_FSTAT, rd);  chk("both_full", rd, 32'h0000_0544);
    wb_rd(O_FDEBUG, rd); chk("rxstall", rd, 32'h5);
    chk("irq_rx_full", {31'd0, irq}, 32'd1);
    wb_wr(O_CTRL, 32'h4);
    chk("flush_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("flush_rx_ready", {31'd0, rx_ready}, 32'd1);
    wb_rd(O_FSTAT, rd);  chk("flush_fstat", rd, 32'h0000_0A00);
    wb_rd(O_CTRL, rd);   chk("flush_ctrl", rd, 32'h0);
    wb_rd(O_FDEBUG, rd); chk("flush_fdebug", rd, 32'h5);
    chk("flush_irq", {31'd0, irq}, 32'd0);

    // Reset mid-transaction
    wb_wr(O_TXF, 32'h99);
    wb_wr(O_CTRL, 32'h1);
    @(negedge clk); chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'(O_FSTAT); sel = 4'hF;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_dat", rdat, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_mid_tx_data", tx_data, 32'd0);
    chk("rst_mid_rx_ready", {31'd0, rx_ready}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wb_rd(O_FSTAT, rd);  chk("post_rst_fstat", rd, 32'h0000_0A00);
    wb_rd(O_FDEBUG, rd); chk("post_rst_fdebug", rd, 32'h0);
    wb_rd(O_CTRL, rd);   chk("post_rst_ctrl", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
